// File: rtl/test_data.sv
// -----------------------------------------------------------------------------
// test_data : challenge-symbol generator for the button game.
//
// A free-running Galois LFSR produces pseudo-random bits. When the stage
// controller raises stage1 or stage3, the LFSR value from before that edge's
// step is copied into the symbol outputs as one or three 2-bit symbols.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rstgame  in   1  synchronous active-low reset
//   button   in   4  player buttons, one-hot (bit i = symbol i)
//   stage1   in   1  level: stage-1 round active
//   stage3   in   1  level: stage-3 round active
//   data1    out  2  challenge symbol 1
//   data2    out  2  challenge symbol 2 (0 in a stage-1 round)
//   data3    out  2  challenge symbol 3 (0 in a stage-1 round)
//
// Configuration macro
//   TESTDATA_BTN_ENTROPY_EN : when defined, each fresh single-button press
//   XORs the button index into lfsr[1:0] after the step. When undefined,
//   button is ignored and the LFSR runs as a pure sequence.
// -----------------------------------------------------------------------------
module test_data #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
  input  logic       clk,
  input  logic       rstgame,
  input  logic [3:0] button,
  input  logic       stage1,
  input  logic       stage3,
  output logic [1:0] data1,
  output logic [1:0] data2,
  output logic [1:0] data3
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S3   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr, lfsr_step, lfsr_d;
  logic              stage1_q, stage3_q;
  logic              rise1, rise3;
  logic [1:0]        data1_d, data2_d, data3_d;

  // Registered edge detection: a rise is seen on the first edge at which the
  // level is sampled high.
  assign rise1 = stage1 & ~stage1_q;
  assign rise3 = stage3 & ~stage3_q;

  // One Galois step to the right.
  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

`ifdef TESTDATA_BTN_ENTROPY_EN
  logic [3:0] button_q;
  logic       press_valid;
  logic [1:0] press_idx;
  logic [LFSR_W-1:0] lfsr_mixed;

  // A press counts only on the edge where a single button appears out of an
  // all-released history, so a held button mixes exactly once.
  assign press_valid = (button != 4'b0000) &&
                       ((button & (button - 4'd1)) == 4'b0000) &&
                       (button_q == 4'b0000);

  always_comb begin
    press_idx = 2'd0;
    case (button)
      4'b0010: press_idx = 2'd1;
      4'b0100: press_idx = 2'd2;
      4'b1000: press_idx = 2'd3;
      default: press_idx = 2'd0;
    endcase
  end

  assign lfsr_mixed = press_valid ? (lfsr_step ^ {{(LFSR_W-2){1'b0}}, press_idx})
                                  : lfsr_step;

  // The all-zero state is a lock-up point for the LFSR; escape to SEED.
  assign lfsr_d = (lfsr_mixed == '0) ? SEED : lfsr_mixed;

  always_ff @(posedge clk) begin
    if (!rstgame) begin
      button_q <= 4'b0000;
    end else begin
      button_q <= button;
    end
  end
`else
  logic unused_button;
  assign unused_button = ^button;

  // The all-zero state is a lock-up point for the LFSR; escape to SEED.
  assign lfsr_d = (lfsr_step == '0) ? SEED : lfsr_step;
`endif

  // Next-state and next-output logic. Symbols are taken from the current
  // (pre-step) register value; stage3 has priority over stage1.
  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise
    // unassigned paths would infer latches.
    state_d = state_q;
    data1_d = data1;
    data2_d = data2;
    data3_d = data3;
    if (rise3) begin
      state_d = S3;
      data1_d = lfsr[1:0];
      data2_d = lfsr[3:2];
      data3_d = lfsr[5:4];
    end else if (rise1) begin
      state_d = S1;
      data1_d = lfsr[1:0];
      data2_d = 2'b00;
      data3_d = 2'b00;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk) begin
    if (!rstgame) begin
      lfsr     <= SEED;
      state_q  <= IDLE;
      stage1_q <= 1'b0;
      stage3_q <= 1'b0;
      data1    <= 2'b00;
      data2    <= 2'b00;
      data3    <= 2'b00;
    end else begin
      lfsr     <= lfsr_d;
      state_q  <= state_d;
      stage1_q <= stage1;
      stage3_q <= stage3;
      data1    <= data1_d;
      data2    <= data2_d;
      data3    <= data3_d;
    end
  end

endmodule

// File: tb/tb_test_data.sv
// -----------------------------------------------------------------------------
// Testbench for test_data. Directed stimulus with hand-computed expected
// symbols; a driver pushes the expected outputs for each edge into a queue and
// a separate monitor pops and compares them just after that edge.
//
// LFSR sequence from SEED (value sampled at non-reset edge k):
//   k0 ACE1  k1 E270  k2 7138  k3 389C  k4 1C4E  k5 0E27  k6 B313  k7 ED89
//   k8 C2C4  k9 6162  k10 30B1 k11 AC58 k12 562C k13 2B16 k14 158B k15 BEC5
//   k16 EB62 k17 75B1 k18 8ED8 k19 476C k20 23B6
// With entropy mixing and button 0010 pressed at k0: k1 E271, k2 C538.
// -----------------------------------------------------------------------------
module tb_test_data;

  logic       clk;
  logic       rstgame;
  logic [3:0] button;
  logic       stage1;
  logic       stage3;
  logic [1:0] data1, data2, data3;

  typedef struct {
    logic [1:0] d1;
    logic [1:0] d2;
    logic [1:0] d3;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;

  test_data dut (
    .clk    (clk),
    .rstgame(rstgame),
    .button (button),
    .stage1 (stage1),
    .stage3 (stage3),
    .data1  (data1),
    .data2  (data2),
    .data3  (data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got d1=%b d2=%b d3=%b, expected d1=%b d2=%b d3=%b",
               nm, act[5:4], act[3:2], act[1:0], req[5:4], req[3:2], req[1:0]);
    end
  endtask

  // Monitor: compares the outputs after each edge for which an expectation
  // was queued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, {data1, data2, data3}, {e.d1, e.d2, e.d3});
      end
    end
  end

  // Driver: apply inputs for one edge (called at a negedge) and queue the
  // outputs expected right after that edge.
  task automatic step(input logic r, input logic s1, input logic s3,
                      input logic [3:0] b, input logic [1:0] e1,
                      input logic [1:0] e2, input logic [1:0] e3,
                      input string nm);
    exp_t e;
    rstgame = r;
    stage1  = s1;
    stage3  = s3;
    button  = b;
    e.d1 = e1;
    e.d2 = e2;
    e.d3 = e3;
    e.name = nm;
    exp_q.push_back(e);
    pushed++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstgame = 1'b0;
    stage1  = 1'b0;
    stage3  = 1'b0;
    button  = 4'b0000;
    @(negedge clk);

    // Reset for two edges.
    step(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_0");
    step(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_1");

    // k0: stage3 rise samples ACE1.
    step(1, 0, 1, 4'b0000, 2'b01, 2'b00, 2'b10, "s3_first_edge");
    // k1: stage1 rise samples E270.
    step(1, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "s1_second_edge");
    step(1, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "s1_level_hold");
    // k3: stage3 rise samples 389C; then held for nine more edges.
    step(1, 0, 1, 4'b0000, 2'b00, 2'b11, 2'b01, "s3_load");
    for (int i = 0; i < 9; i++)
      step(1, 0, 1, 4'b0000, 2'b00, 2'b11, 2'b01, "s3_level_hold");
    step(1, 0, 0, 4'b0000, 2'b00, 2'b11, 2'b01, "s3_drop_hold");
    // k14: stage3 rises again, samples 158B.
    step(1, 0, 1, 4'b0000, 2'b11, 2'b10, 2'b00, "s3_reload");
    step(1, 0, 0, 4'b0000, 2'b11, 2'b10, 2'b00, "idle_hold");
    // k16: both rise together, stage3 wins, samples EB62.
    step(1, 1, 1, 4'b0000, 2'b10, 2'b00, 2'b10, "both_rise_s3_wins");
    step(1, 1, 1, 4'b0000, 2'b10, 2'b00, 2'b10, "both_level_hold");
    step(1, 1, 0, 4'b0000, 2'b10, 2'b00, 2'b10, "s1_level_no_reload");
    step(1, 0, 0, 4'b0000, 2'b10, 2'b00, 2'b10, "all_low_hold");
    // k20: stage1 rise samples 23B6.
    step(1, 1, 0, 4'b0000, 2'b10, 2'b00, 2'b00, "s1_reload");
    // Reset mid-round clears outputs; stage1 history clears, so the held
    // level is seen as a new rise at the first edge after reset (ACE1).
    step(0, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_mid_round");
    step(1, 1, 0, 4'b0000, 2'b01, 2'b00, 2'b00, "rise_after_reset");

    // Button held for three edges, stage3 rise at k2: C538 (mixed once)
    // or 7138 (unmixed); both give the same low six bits.
    step(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_a");
    step(1, 0, 0, 4'b0010, 2'b00, 2'b00, 2'b00, "btn_held_k0");
    step(1, 0, 0, 4'b0010, 2'b00, 2'b00, 2'b00, "btn_held_k1");
    step(1, 0, 1, 4'b0010, 2'b00, 2'b10, 2'b11, "btn_held_once");

    // Single press at k0, stage3 rise at k1: E271 when mixing, E270 otherwise.
    step(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_b");
    step(1, 0, 0, 4'b0010, 2'b00, 2'b00, 2'b00, "btn_press_k0");
`ifdef TESTDATA_BTN_ENTROPY_EN
    step(1, 0, 1, 4'b0000, 2'b01, 2'b00, 2'b11, "btn_press_mixed");
`else
    step(1, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b11, "btn_press_ignored");
`endif

    // Two buttons at once never mix: stage3 rise at k1 samples E270.
    step(0, 0, 0, 4'b0000, 2'b00, 2'b00, 2'b00, "reset_c");
    step(1, 0, 0, 4'b1010, 2'b00, 2'b00, 2'b00, "btn_multi_k0");
    step(1, 0, 1, 4'b0000, 2'b00, 2'b00, 2'b11, "btn_multi_no_mix");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || checks != pushed + 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, %0d compared, %0d expected",
               exp_q.size(), checks - 1, pushed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
